// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES <-> UART byte paths: block geometry,
// receiver state encoding and the byte-slot mapping used by RX and TX.
package aes_uart_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // MSB index of byte slot n: slot 0 is [127:120], slot 15 is [7:0].
  function automatic logic [6:0] slot_msb(input logic [3:0] n);
    return 7'd127 - {n, 3'b000};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser plus start/data/stop state machine.
// byte_strb and frame_err are single-cycle registered pulses; byte_data is
// valid while byte_strb is high. rx_idle reports the receiver is between frames.
module uart_rx
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_strb,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       rx_idle
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  logic          rx_meta_r;
  logic          rx_sync_r;
  rx_state_t     state_r;
  rx_state_t     state_nx_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_nx_s;
  logic [2:0]    bit_idx_r;
  logic [2:0]    bit_idx_nx_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_nx_s;
  logic          byte_strb_r;
  logic          strb_nx_s;
  logic          frame_err_r;
  logic          ferr_nx_s;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state, bit timer and sampling decisions for one frame.
  always_comb begin
    state_nx_s   = state_r;
    timer_nx_s   = timer_r + TW'(1);
    bit_idx_nx_s = bit_idx_r;
    shift_nx_s   = shift_r;
    strb_nx_s    = 1'b0;
    ferr_nx_s    = 1'b0;
    case (state_r)
      IDLE: begin
        timer_nx_s = '0;
        if (!rx_sync_r) begin
          state_nx_s = START;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        if (timer_r == HALF_M1) begin
          timer_nx_s   = '0;
          bit_idx_nx_s = 3'd0;
          // A start bit that is high again at its centre was only a glitch.
          if (!rx_sync_r) begin
            state_nx_s = DATA;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = START;
        end
      end
      DATA: begin
        if (timer_r == FULL_M1) begin
          timer_nx_s   = '0;
          shift_nx_s   = {rx_sync_r, shift_r[7:1]};
          bit_idx_nx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_nx_s = STOP;
          end else begin
            state_nx_s = DATA;
          end
        end else begin
          state_nx_s = DATA;
        end
      end
      STOP: begin
        if (timer_r == FULL_M1) begin
          // Leave at mid stop bit so the next start edge is never missed.
          timer_nx_s = '0;
          state_nx_s = IDLE;
          if (rx_sync_r) begin
            strb_nx_s = 1'b1;
          end else begin
            ferr_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = STOP;
        end
      end
      default: begin
        state_nx_s = IDLE;
        timer_nx_s = '0;
      end
    endcase
  end

  // Frame state, timer, shift register and output pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      timer_r     <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      byte_strb_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      timer_r     <= timer_nx_s;
      bit_idx_r   <= bit_idx_nx_s;
      shift_r     <= shift_nx_s;
      byte_strb_r <= strb_nx_s;
      frame_err_r <= ferr_nx_s;
    end
  end

  assign byte_strb = byte_strb_r;
  assign byte_data = shift_r;
  assign frame_err = frame_err_r;
  assign rx_idle   = (state_r == IDLE);

endmodule

// File: rtl/uart_rx_to_aes.sv
// UART receive path feeding the AES core: collects 16 received bytes into a
// 128-bit block (first byte in [127:120]) and offers it on a valid/ready
// handshake through an output register separate from the assembly register.
// Optional feature macro: RX_TIMEOUT_EN discards a partial block after
// TIMEOUT_BITS idle bit periods.
module uart_rx_to_aes
  import aes_uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic [BLOCK_W-1:0] block,
  output logic               block_valid,
  input  logic               block_ready,
  output logic [3:0]         byte_cnt,
  output logic               frame_err,
  output logic               overrun
);

`ifdef RX_TIMEOUT_EN
  localparam logic TIMEOUT_ON = 1'b1;
`else
  localparam logic TIMEOUT_ON = 1'b0;
`endif
  localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT_BITS * CLKS_PER_BIT);

  logic               byte_strb_s;
  logic [7:0]         byte_data_s;
  logic               rx_idle_s;
  logic [BLOCK_W-1:0] asm_r;
  logic [BLOCK_W-1:0] asm_nx_s;
  logic [3:0]         byte_cnt_r;
  logic [BLOCK_W-1:0] block_r;
  logic               block_valid_r;
  logic               overrun_r;
  logic               complete_s;
  logic               consume_s;
  logic               load_s;
  logic               drop_s;
  logic [31:0]        idle_cnt_r;
  logic               timeout_s;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .byte_strb(byte_strb_s),
    .byte_data(byte_data_s),
    .frame_err(frame_err),
    .rx_idle  (rx_idle_s)
  );

  // Assembly register with the incoming byte placed in its slot, and the
  // completion / handshake decisions derived from it.
  always_comb begin
    asm_nx_s = asm_r;
    asm_nx_s[slot_msb(byte_cnt_r) -: 8] = byte_data_s;
    complete_s = byte_strb_s && (byte_cnt_r == 4'd15);
    consume_s  = block_valid_r && block_ready;
    load_s     = complete_s && (!block_valid_r || consume_s);
    drop_s     = complete_s && !load_s;
    timeout_s  = TIMEOUT_ON && rx_idle_s && (byte_cnt_r != 4'd0) &&
                 (idle_cnt_r == TIMEOUT_CYC);
  end

  // Byte slot counter and assembly register; the counter wraps on byte 16.
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_r      <= '0;
      byte_cnt_r <= 4'd0;
    end else if (byte_strb_s) begin
      asm_r      <= asm_nx_s;
      byte_cnt_r <= byte_cnt_r + 4'd1;
    end else if (timeout_s) begin
      byte_cnt_r <= 4'd0;
    end else begin
      asm_r      <= asm_r;
      byte_cnt_r <= byte_cnt_r;
    end
  end

  // Output register: load a completed block when free or being consumed,
  // otherwise keep the old block and flag the drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      block_r       <= '0;
      block_valid_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      overrun_r <= drop_s;
      if (load_s) begin
        block_r       <= asm_nx_s;
        block_valid_r <= 1'b1;
      end else if (consume_s) begin
        block_valid_r <= 1'b0;
      end else begin
        block_valid_r <= block_valid_r;
      end
    end
  end

  // Inter-byte idle counter; only advances with a partial block pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_r <= 32'd0;
    end else if (!TIMEOUT_ON || byte_strb_s || timeout_s ||
                 !rx_idle_s || (byte_cnt_r == 4'd0)) begin
      idle_cnt_r <= 32'd0;
    end else begin
      idle_cnt_r <= idle_cnt_r + 32'd1;
    end
  end

  assign block       = block_r;
  assign block_valid = block_valid_r;
  assign byte_cnt    = byte_cnt_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_uart_rx_to_aes.sv
// Self-checking bench for uart_rx_to_aes. Runs at 16 clocks per bit
// (115200 baud on a 1.8432 MHz clock) to keep frames short.
module tb_uart_rx_to_aes;

  localparam int CPB  = 16;
  localparam int BAUD = 115200;
  localparam int CLKF = CPB * BAUD;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx = 1'b1;
  logic         block_ready = 1'b0;
  logic [127:0] block;
  logic         block_valid;
  logic [3:0]   byte_cnt;
  logic         frame_err;
  logic         overrun;

  int tests = 0;
  int fails = 0;

  // Pulse/handshake monitor (sampled on the falling edge).
  int           acc_cnt = 0;
  int           ferr_cnt = 0;
  int           ovr_cnt = 0;
  logic [127:0] acc_blk = '0;

  // Reference model state.
  logic [7:0]   q_bytes[$];
  int           exp_acc = 0;
  int           exp_ferr = 0;
  int           exp_ovr = 0;
  logic [127:0] exp_blk = '0;
  logic         mdl_valid = 1'b0;
  logic [127:0] mdl_block = '0;

  always #5 clk = ~clk;

  uart_rx_to_aes #(
    .CLK_FREQ    (CLKF),
    .BAUD_RATE   (BAUD),
    .TIMEOUT_BITS(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .block      (block),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .byte_cnt   (byte_cnt),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always @(negedge clk) begin
    if (block_valid && block_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_blk <= block;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold the line at level v for n clock cycles.
  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A finished block is taken at once if ready, else parked, else lost.
  task automatic model_complete(input logic [127:0] blk);
    if (block_ready) begin
      exp_acc++;
      exp_blk = blk;
    end else if (!mdl_valid) begin
      mdl_valid = 1'b1;
      mdl_block = blk;
    end else begin
      exp_ovr++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [127:0] blk;
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(b[i], CPB);
    line(stop_ok, CPB);
    if (!stop_ok) begin
      line(1'b1, 2 * CPB);
      exp_ferr++;
    end else begin
      q_bytes.push_back(b);
      if (q_bytes.size() == 16) begin
        blk = '0;
        for (int i = 0; i < 16; i++) blk = {blk[119:0], q_bytes[i]};
        q_bytes.delete();
        model_complete(blk);
      end
    end
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic release_ready();
    block_ready = 1'b1;
    line(1'b1, 3);
    if (mdl_valid) begin
      exp_acc++;
      exp_blk = mdl_block;
      mdl_valid = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".byte_cnt"}, 128'(byte_cnt), 128'(q_bytes.size()));
    chk({tag, ".accepts"}, 128'(acc_cnt), 128'(exp_acc));
    chk({tag, ".acc_block"}, acc_blk, exp_blk);
    chk({tag, ".frame_errs"}, 128'(ferr_cnt), 128'(exp_ferr));
    chk({tag, ".overruns"}, 128'(ovr_cnt), 128'(exp_ovr));
    chk({tag, ".valid"}, 128'(block_valid), 128'(mdl_valid));
    if (mdl_valid) chk({tag, ".held_block"}, block, mdl_block);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".block"}, block, 128'd0);
    chk({tag, ".valid"}, 128'(block_valid), 128'd0);
    chk({tag, ".byte_cnt"}, 128'(byte_cnt), 128'd0);
    chk({tag, ".frame_err"}, 128'(frame_err), 128'd0);
    chk({tag, ".overrun"}, 128'(overrun), 128'd0);
  endtask

  logic [7:0] vec[16] = '{8'hd3, 8'h02, 8'h16, 8'hc8, 8'h3d, 8'h90, 8'h2e, 8'h50,
                         8'h90, 8'h29, 8'h1c, 8'h9d, 8'h37, 8'h8f, 8'hfc, 8'h08};

  initial begin
    // Reset values.
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals("reset");
    line(1'b1, 2 * CPB);

    // Known vector with the consumer always ready.
    block_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_byte(vec[i], 1'b1);
      chk("vec.byte_cnt", 128'(byte_cnt), 128'((i + 1) % 16));
    end
    check_state("vec");
    chk("vec.literal", acc_blk, 128'hd30216c83d902e5090291c9d378ffc08);

    // Random block, consumer ready.
    send_random(16);
    check_state("rand");

    // Consumer stalled: first block held, second dropped.
    block_ready = 1'b0;
    send_random(16);
    check_state("stall1");
    send_random(16);
    check_state("stall2");
    release_ready();
    check_state("release");

    // Bad stop bit mid-block and on what would be the 16th byte.
    send_random(3);
    send_byte(8'h55, 1'b0);
    check_state("ferr");
    send_random(12);
    check_state("ferr15");
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    check_state("ferr16");
    send_random(1);
    check_state("ferr_done");

    // Short low glitch: no byte, no error.
    line(1'b0, CPB / 4);
    line(1'b1, 3 * CPB);
    check_state("glitch");
    send_random(16);
    check_state("post_glitch");

`ifdef RX_TIMEOUT_EN
    // Partial block abandoned after 40 idle bit periods.
    send_random(5);
    line(1'b1, 40 * CPB);
    q_bytes.delete();
    check_state("timeout");
    send_random(16);
    check_state("post_timeout");
`endif

    // Reset in the middle of the 9th byte.
    send_random(8);
    line(1'b0, CPB);
    line(1'b1, 3 * CPB);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q_bytes.delete();
    mdl_valid = 1'b0;
    check_reset_vals("midreset");
    line(1'b1, 2 * CPB);
    send_random(16);
    check_state("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_to_aes.md
# uart_rx_to_aes

Receive-side counterpart of the AES-to-UART transmit path. Deserialises 8N1 UART frames from the `rx` pin, assembles 16 consecutive bytes into one 128-bit block, and offers it to the AES core over a valid/ready handshake. The block sits between the board RX pin and the AES input register, and mirrors the transmit path's byte order and baud timing.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: UART bit rate.
- `CLKS_PER_BIT`, default CLK_FREQ/BAUD_RATE (434): clock cycles per bit period. Integer division; must be at least 8.
- `TIMEOUT_BITS`, default 32: inter-byte idle limit in bit periods. Used only when `RX_TIMEOUT_EN` is defined.

- `clk`, in, 1: single system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `rx`, in, 1: asynchronous UART line. Idles high.
- `block`, out, 128: assembled block. The first received byte is at [127:120]; the 16th byte is at [7:0].
- `block_valid`, out, 1: `block` holds an unconsumed block.
- `block_ready`, in, 1: consumer accepts `block` in any cycle where `block_valid` and `block_ready` are both high.
- `byte_cnt`, out, 4: number of bytes of the current partial block received so far (0..15).
- `frame_err`, out, 1: one-cycle pulse when a stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a completed block is dropped.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- RX state machine: IDLE → START → DATA → STOP → IDLE.
  - IDLE: wait for synchronised `rx`=0, then clear the bit-timer and go to START.
  - START: at timer = CLKS_PER_BIT/2−1 (mid start bit), sample `rx`.
    - `rx`=0: go to DATA and clear the timer.
    - `rx`=1: treat as a glitch and return to IDLE with no output.
  - DATA: sample at each timer = CLKS_PER_BIT−1. Shift bits in LSB first. After 8 bits, go to STOP.
  - STOP: sample after one further CLKS_PER_BIT.
    - `rx`=1: the byte is good; pulse the internal `byte_strb`.
    - `rx`=0: pulse `frame_err` and discard the byte. `byte_cnt` is unchanged.
    - Either way, return to IDLE on the next cycle.
- Assembler, on `byte_strb`:
  - Write the byte into slot `byte_cnt` of the 128-bit shift/assembly register, then increment `byte_cnt`.
  - On the 16th byte, `byte_cnt` wraps 15→0 and the block is complete.
- Completion, with an output register separate from the assembly register:
  - If the output register is free, or is being consumed in that same cycle: load `block` and hold `block_valid`=1.
  - Otherwise: pulse `overrun` and drop the new block. The old `block` is retained unchanged.
- `block` is stable while `block_valid`=1. `block_valid` clears on the handshake cycle unless a new block loads in that same cycle.
- Reset at any time, including mid-byte or mid-block: state returns to IDLE, the partial block is discarded, and all counters clear.

## Timing
- Reset values: `block`=0, `block_valid`=0, `byte_cnt`=0, `frame_err`=0, `overrun`=0. Internal `rx` sync flops = 1.
- Byte latency: `byte_strb` fires 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the start-bit falling edge on the `rx` pin (±1 cycle of sampling phase).
- `block_valid` rises 1 cycle after the 16th `byte_strb`.
- Back-to-back frames are supported. After STOP, the block is in IDLE early enough to detect the next start bit at full baud.
- Simultaneous events:
  - Completion together with a handshake: no overrun, and `block_valid` stays 1 with the new data.
  - `frame_err` on what would have been the 16th byte: no completion.

## Configuration
- `RX_TIMEOUT_EN` defined:
  - An idle counter runs while `byte_cnt`≠0 and the state is IDLE.
  - When it reaches TIMEOUT_BITS·CLKS_PER_BIT, `byte_cnt` clears and the partial block is discarded. No error pulse is raised.
  - The counter clears on every `byte_strb`.
- `RX_TIMEOUT_EN` undefined: no idle counter. A partial block waits indefinitely. `TIMEOUT_BITS` is unused.

## Structure
- Shared package `aes_uart_pkg`:
  - `BLOCK_BYTES`=16.
  - `rx_state_t` enum (IDLE, START, DATA, STOP).
  - Byte-slot index function mapping slot n to bits [127−8n −: 8], shared with the TX path.
- One sub-module `uart_rx`: the synchroniser plus the RX state machine. It outputs `byte_strb`, `byte_data[7:0]` and `frame_err`.
- The top-level `uart_rx_to_aes` holds the assembler, the output register/handshake, and the optional timeout.

## Test plan
- Send bytes d3 02 16 c8 3d 90 2e 50 90 29 1c 9d 37 8f fc 08 at 115200 baud with `block_ready`=1 → one `block_valid` pulse with `block`=128'hd30216c83d902e5090291c9d378ffc08; `byte_cnt` returns to 0.
- Hold `block_ready`=0 and send two full blocks → one `overrun` pulse at the second completion; `block` still holds the first block; asserting `block_ready` clears `block_valid`.
- Send byte 0x55 with its stop bit driven low → `frame_err` pulses once, `byte_cnt` unchanged, and the next valid byte is accepted normally.
- Drive a low glitch on `rx` lasting 100 cycles → no byte, no `frame_err`, state returns to IDLE.
- With `RX_TIMEOUT_EN`: send 5 bytes, idle for 40 bit periods → `byte_cnt`=0; a following 16-byte sequence yields the correct block.
- Assert `reset` during the 9th byte for 1 cycle → all outputs are at reset values; a fresh 16-byte sequence assembles correctly.
